// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU types: RAM handshake state and arbiter FSM state
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'b00,
        BUSY   = 2'b01,
        ACCESS = 2'b10,
        ERROR  = 2'b11
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IGNT = 2'b01,
        DGNT = 2'b10
    } arb_state_t;

    localparam int unsigned ARB_CNT_W = 16;

endpackage

// File: rtl/arb_timeout_counter.sv
// rtl/arb_timeout_counter.sv - 16-bit saturating stall counter for the RAM arbiter grant
module arb_timeout_counter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    input  logic saturate,
    output logic hit
);

    logic [ARB_CNT_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !(saturate && count == '1)) begin
            count <= count + 1'b1;
        end
    end

    // The stalled cycle in progress counts too, so hit fires on the TIMEOUT-th stalled cycle.
    assign hit = enable && (({1'b0, count} + 17'd1) >= 17'(TIMEOUT));

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - single-port RAM arbiter between instruction fetch and data requester (ARB_ROUND_ROBIN_EN)
module ram_arbiter
    import cpu_types_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  ramstate_t   ramstate,
    output logic        err
);

    arb_state_t state;
    logic       prio_d;
    logic       dreq;
    logic       granted;
    logic       gnt_req;
    logic       access;
    logic       abort;
    logic       done;
    logic       hit;

    assign dreq    = dREN | dWEN;
    assign granted = (state != IDLE);
    assign gnt_req = (state == IGNT) ? iREN : (state == DGNT) ? dreq : 1'b0;
    assign access  = granted && gnt_req && (ramstate == ACCESS);
    // ACCESS outranks both ERROR and timeout; a dropped request is never an abort.
    assign abort   = granted && gnt_req && !access && ((ramstate == ERROR) || hit);
    assign done    = access || abort;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (CLK),
        .rst      (RST),
        .clear    (!granted),
        .enable   (granted && (ramstate != ACCESS)),
        .saturate (1'b1),
        .hit      (hit)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            prio_d <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (dreq && (prio_d || !iREN))
                        state <= DGNT;
                    else if (iREN)
                        state <= IGNT;
                end
                IGNT: if (!iREN || done) state <= IDLE;
                DGNT: if (!dreq || done) state <= IDLE;
                default: state <= IDLE;
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            if (done)
                prio_d <= !prio_d;
`else
            prio_d <= 1'b1;
`endif
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        unique case (state)
            IGNT: begin
                ramREN  = 1'b1;
                ramaddr = iaddr;
                iload   = access ? ramload : '0;
            end
            DGNT: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = access ? ramload : '0;
            end
            default: ;
        endcase
    end

    assign iwait = iREN && !((state == IGNT) && done);
    assign dwait = dreq && !((state == DGNT) && done);
    assign err   = abort;

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Sequences the single RAM port between the instruction-fetch requester (read-only) and the data requester (read/write) of one core. It sits between the datapath's cache-side interface and memory. It latches one grant at a time, holds it until RAM reports ACCESS or an error or timeout occurs, and returns per-requester wait and load signals.

## Interface
- TIMEOUT, 255: consecutive non-ACCESS cycles allowed under a grant before abort; legal range 1..65535.
- CLK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  instruction read request; held until iwait low.
- iaddr  in  32  instruction word address.
- iwait  out  1  high while the instruction request is pending.
- iload  out  32  instruction read data; valid when iwait is low and iREN is high.
- dREN, dWEN  in  1 each  data read/write request; mutually exclusive, held until dwait low.
- daddr  in  32  data address.
- dstore  in  32  write data.
- dwait  out  1  high while the data request is pending.
- dload  out  32  data read data.
- ramREN, ramWEN  out  1 each  RAM strobes.
- ramaddr, ramstore  out  32 each  RAM address and write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  one-cycle pulse on an aborted transaction.

## Operation
- FSM states: IDLE, IGNT, DGNT.
- IDLE: no RAM strobes. Both waits are high if the corresponding request is asserted.
- IDLE, next-state priority: if (dREN|dWEN) and the priority bit selects D, or no iREN → DGNT. Else if iREN → IGNT. Else stay.
- IGNT: ramREN=1, ramaddr=iaddr. dwait stays high.
- DGNT: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore. iwait stays high.
- Under a grant with ramstate==ACCESS: the granted wait goes low combinationally in the same cycle, and load = ramload. Next state is IDLE.
- Under a grant with ramstate==ERROR, or the timeout counter reaching TIMEOUT: the granted wait goes low, load = 0, err=1 for that cycle. Next state is IDLE.
- Requester dropping its request while granted: abandon the grant, go to IDLE next cycle, no err.
- Timeout counter: 16 bits, cleared on entry to a grant, increments each granted cycle without ACCESS. Saturates and does not wrap.
- The non-granted wait is always high while its request is asserted.
- Outputs without an active grant: strobes 0, addr/store 0, loads 0.

## Timing
- Reset state: IDLE, counter 0, priority bit = D. All outputs 0 except waits, which follow the request inputs combinationally (wait = request).
- Minimum latency: request at cycle 0 → grant state at cycle 1 → ACCESS at the earliest in cycle 1 → wait low in cycle 1.
- Every grant passes through IDLE for at least one cycle, so back-to-back grants are separated by one idle cycle.
- Simultaneous iREN and dREN/dWEN in IDLE: resolved per the priority rule; the loser waits through the full winner grant plus the IDLE cycle.
- Reset asserted mid-grant: all strobes drop asynchronously, FSM goes to IDLE, no err pulse.
- TIMEOUT reached in the same cycle as ACCESS: ACCESS wins, no err.

## Configuration
- ARB_ROUND_ROBIN_EN defined: the priority bit toggles after every completed or aborted grant, giving the other requester precedence at the next contention.
- Undefined: the priority bit is fixed at D. The data requester always wins contention, and instruction fetch may starve under continuous data traffic.

## Structure
- Shared package cpu_types_pkg: ramstate_t (existing) and a new arb_state_t enum {IDLE, IGNT, DGNT}.
- One sub-module, arb_timeout_counter: clear, enable and saturate inputs; hit output when count ≥ TIMEOUT.
- The FSM, priority bit and output muxing stay in ram_arbiter.

## Test plan
- Reset: assert RST mid-DGNT with ramWEN=1 → ramWEN=0 immediately; state IDLE; err=0.
- Instruction read alone: iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C220004 → iwait low in cycle 3, iload=0x8C220004, next cycle IDLE.
- Contention: iREN and dREN both rise at cycle 0, each RAM access takes 1 cycle → D granted first. With ARB_ROUND_ROBIN_EN, a second contention grants I first; without it, D again.
- Data write: dWEN=1, daddr=0x100, dstore=0xDEADBEEF → ramWEN=1 and ramstore=0xDEADBEEF until ACCESS; iREN held high sees iwait=1 throughout.
- Timeout: TIMEOUT=4, ramstate stuck BUSY → err=1 and dwait=0 at granted cycle 4; dload=0.
- ERROR and abandon: ramstate=ERROR during IGNT → err pulse, iwait low. dREN dropped mid-DGNT → IDLE next cycle, no err.
